// File: rtl/opl3_pkg.sv
// Shared OPL3 register-file types: the write stream into the register file
// and the per-requester write request used by the write arbiter.
package opl3_pkg;

   localparam int REG_FILE_ADDRESS_WIDTH = 8;
   localparam int REG_FILE_DATA_WIDTH    = 8;
   localparam int REG_WR_ARB_NUM_REQ     = 3;

   typedef struct packed {
      logic                              valid;
      logic                              bank_num;
      logic [REG_FILE_ADDRESS_WIDTH-1:0] address;
      logic [REG_FILE_DATA_WIDTH-1:0]    data;
   } opl3_reg_wr_t;

   typedef struct packed {
      logic                              bank_num;
      logic [REG_FILE_ADDRESS_WIDTH-1:0] address;
      logic [REG_FILE_DATA_WIDTH-1:0]    data;
   } reg_wr_req_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_HOLD
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr,
// wrapping modulo N. Produces both a one-hot grant and its index.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic [N-1:0]         req_valid,
   input  logic [$clog2(N)-1:0] rr_ptr,
   input  logic                 enable,
   output logic [N-1:0]         grant_onehot,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IDX_W = $clog2(N);

   logic [N-1:0]   rotated;
   logic [IDX_W:0] sum;
   logic           found;

   // Rotate so that bit 0 is the requester rr_ptr points at.
   assign rotated = N'({req_valid, req_valid} >> rr_ptr);

   always_comb begin
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < N; k++) begin
         if (enable && !found && rotated[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
               sum = sum - (IDX_W+1)'(N);
            end
         end
      end
      grant_idx    = sum[IDX_W-1:0];
      grant_onehot = found ? (N'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/opl3_reg_wr_arbiter.sv
// Round-robin merge of NUM_REQ register-write requesters into one opl3_reg_wr
// stream with MIN_GAP idle cycles after each write. Grant counters exist only
// when OPL3_REG_WR_ARB_STATS_EN is defined.
module opl3_reg_wr_arbiter
   import opl3_pkg::*;
#(
   parameter int NUM_REQ = REG_WR_ARB_NUM_REQ,
   parameter int MIN_GAP = 0,
   parameter int CNT_W   = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  reg_wr_req_t [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]                req_ready,
   output opl3_reg_wr_t                      opl3_reg_wr,
   output logic                              busy,
   input  logic                              stats_clr,
   output logic [NUM_REQ-1:0][CNT_W-1:0]     grant_count
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t         state;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   rr_ptr_next;
   logic [IDX_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant_onehot;
   logic [7:0]         gap_cnt;
   logic               grant;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_valid    (req_valid),
      .rr_ptr       (rr_ptr),
      .enable       (state == ARB_IDLE),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx)
   );

   assign req_ready   = grant_onehot;
   assign grant       = |grant_onehot;
   assign rr_ptr_next = (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
   assign busy        = (state == ARB_HOLD) || opl3_reg_wr.valid;

   // Reset in a grant cycle drops the output pulse; the requester already saw ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ARB_IDLE;
         rr_ptr      <= '0;
         gap_cnt     <= '0;
         opl3_reg_wr <= '0;
      end else begin
         opl3_reg_wr.valid <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant) begin
                  opl3_reg_wr <= {1'b1, req[grant_idx]};
                  rr_ptr      <= rr_ptr_next;
                  if (MIN_GAP != 0) begin
                     gap_cnt <= 8'(MIN_GAP);
                     state   <= ARB_HOLD;
                  end
               end
            end
            ARB_HOLD: begin
               gap_cnt <= gap_cnt - 8'd1;
               if (gap_cnt == 8'd1) begin
                  state <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

`ifdef OPL3_REG_WR_ARB_STATS_EN
   // Clear wins over a same-cycle grant; counters saturate at all-ones.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      always_ff @(posedge clk) begin
         if (reset || stats_clr) begin
            grant_count[gi] <= '0;
         end else if (grant_onehot[gi] && (grant_count[gi] != '1)) begin
            grant_count[gi] <= grant_count[gi] + CNT_W'(1);
         end
      end
   end
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign grant_count      = '0;
`endif

endmodule
